// File: rtl/clkswitch_req_ctrl.sv
// Per-access HS/LS clock select controller for clkctrl_phi2; state and outputs update one lsclk edge after inputs.
// While a handover is in flight cpu_rdy stays low. LS dwell hysteresis stops slow/fast interleaving from thrashing the switch.
module clkswitch_req_ctrl #(
    parameter int DWELL_CYCLES = 4,
    parameter int TIMEOUT      = 31,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       lsclk_in,
    input  logic       rst_b,
    input  logic       access_valid,
    input  logic       access_fast,
    input  logic       force_ls,
    input  logic       hsclk_selected,
    input  logic       lsclk_selected,
    input  logic       err_clr,
    output logic       hsclk_sel,
    output logic       cpu_rdy,
    output logic [1:0] state_o,
    output logic       switch_err
);

    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int DW = (DWELL_CYCLES > 0) ? $clog2(DWELL_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TIMEOUT_V = TW'(TIMEOUT);
    localparam logic [DW-1:0] DWELL_V   = DW'(DWELL_CYCLES);

    typedef enum logic [1:0] {
        LS_RUN = 2'b00,
        TO_HS  = 2'b01,
        HS_RUN = 2'b10,
        TO_LS  = 2'b11
    } state_t;

    state_t                 r_state;
    state_t                 w_state;
    logic                   r_hsclk_sel;
    logic                   w_hsclk_sel;
    logic                   r_cpu_rdy;
    logic                   w_cpu_rdy;
    logic                   r_switch_err;
    logic                   w_switch_err;
    logic                   w_err_set;
    logic [TW-1:0]          r_timer;
    logic [TW-1:0]          w_timer;
    logic [DW-1:0]          r_dwell_cnt;
    logic [DW-1:0]          w_dwell_cnt;
    logic [SYNC_STAGES-1:0] r_sync;

    logic w_hs_ok;
    logic w_fast_req;
    logic w_slow_req;

    assign w_hs_ok    = r_sync[SYNC_STAGES-1];
    assign w_fast_req = access_valid & access_fast & ~force_ls;
    assign w_slow_req = force_ls | (access_valid & ~access_fast);

    // hsclk_selected comes from the CPU clock domain.
    always_ff @(posedge lsclk_in or negedge rst_b) begin
        if (!rst_b) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= hsclk_selected;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    always_ff @(posedge lsclk_in or negedge rst_b) begin
        if (!rst_b) begin
            r_state      <= LS_RUN;
            r_hsclk_sel  <= 1'b0;
            r_cpu_rdy    <= 1'b1;
            r_switch_err <= 1'b0;
            r_timer      <= '0;
            r_dwell_cnt  <= '0;
        end else begin
            r_state      <= w_state;
            r_hsclk_sel  <= w_hsclk_sel;
            r_cpu_rdy    <= w_cpu_rdy;
            r_switch_err <= w_switch_err;
            r_timer      <= w_timer;
            r_dwell_cnt  <= w_dwell_cnt;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_hsclk_sel = r_hsclk_sel;
        w_cpu_rdy   = r_cpu_rdy;
        w_timer     = r_timer;
        w_dwell_cnt = r_dwell_cnt;
        w_err_set   = 1'b0;

        case (r_state)
            LS_RUN: begin
                if (r_dwell_cnt != '0) begin
                    w_dwell_cnt = r_dwell_cnt - DW'(1);
                end else if (w_fast_req) begin
                    w_state     = TO_HS;
                    w_hsclk_sel = 1'b1;
                    w_cpu_rdy   = 1'b0;
                    w_timer     = TIMEOUT_V;
                end
            end

            TO_HS: begin
                if (w_hs_ok) begin
                    w_state   = HS_RUN;
                    w_cpu_rdy = 1'b1;
                end else if (r_timer == '0) begin
                    // Abort back to LS; the LS leg gets a fresh timeout.
                    w_err_set   = 1'b1;
                    w_hsclk_sel = 1'b0;
                    w_timer     = TIMEOUT_V;
                    w_state     = TO_LS;
                end else begin
                    w_timer = r_timer - TW'(1);
                end
            end

            HS_RUN: begin
                if (w_slow_req) begin
                    w_state     = TO_LS;
                    w_hsclk_sel = 1'b0;
                    w_cpu_rdy   = 1'b0;
                    w_timer     = TIMEOUT_V;
                end
            end

            TO_LS: begin
                if (lsclk_selected && !w_hs_ok) begin
                    w_state     = LS_RUN;
                    w_cpu_rdy   = 1'b1;
                    w_dwell_cnt = DWELL_V;
                end else if (r_timer == '0) begin
                    // LS is the safe clock, so keep waiting rather than abort.
                    w_err_set = 1'b1;
                end else begin
                    w_timer = r_timer - TW'(1);
                end
            end

            default: begin
                w_state = LS_RUN;
            end
        endcase
    end

    assign w_switch_err = w_err_set | (r_switch_err & ~err_clr);

    assign hsclk_sel  = r_hsclk_sel;
    assign cpu_rdy    = r_cpu_rdy;
    assign state_o    = r_state;
    assign switch_err = r_switch_err;

endmodule
